frame_capture: RTL and testbench
================================

// Module: frame_capture
// PURPOSE
//  Ping-pong sample buffer sitting directly upstream of the pitch shifter.
//  - Collects incoming audio samples into fixed-length frames.
//  - Hands each completed frame to the shifter with a one-cycle Start pulse, then waits for its Done.
//  - Serves the held frame to the shifter through a registered read port while the next frame is captured.
// PARAMETERS
//  SAMPLE_W   16   bits per audio sample
//  FRAME_LEN  256  samples per frame (power of two)
//  ADDR_W     8    log2(FRAME_LEN)
//  CNT_W      8    width of dropped-frame counter
// PORTS
//  Clk           in   1         system clock, all logic on rising edge
//  Reset         in   1         asynchronous, active-high reset
//  Sample_In     in   SAMPLE_W  audio sample, two's complement
//  Sample_Valid  in   1         Sample_In is written this cycle
//  Done          in   1         shifter finished the held frame (1-cycle pulse)
//  Clr_Ovr       in   1         clears Overrun and Drop_Count
//  Rd_Addr       in   ADDR_W    shifter read index into the held frame
//  Rd_Data       out  SAMPLE_W  sample at Rd_Addr, 1-cycle latency
//  Start         out  1         1-cycle pulse: held frame ready for shifter
//  Busy          out  1         shifter owns a frame (state BUSY)
//  Overrun       out  1         sticky: a completed frame was dropped
//  Drop_Count    out  CNT_W     dropped frames, saturating at all-ones
// BEHAVIOUR
//  - Reset values: Start=0, Busy=0, Overrun=0, Drop_Count=0, Rd_Data=0.
//    Internal reset values: wr_idx=0, wr_bank=0, rd_bank=1, state=IDLE. RAM contents are not reset.
//  - Write path: on each Sample_Valid, mem[{wr_bank,wr_idx}] <= Sample_In and wr_idx increments.
//    frame_done = Sample_Valid && wr_idx==FRAME_LEN-1; wr_idx then wraps to 0.
//  - Handoff FSM, states IDLE and BUSY:
//    IDLE, frame_done:            rd_bank<=wr_bank, wr_bank toggles, Start=1 next cycle, go BUSY.
//    BUSY, Done, no frame_done:   go IDLE.
//    BUSY, frame_done, no Done:   overrun. wr_bank does not toggle (next frame overwrites it);
//                                 Overrun<=1; Drop_Count+1 (saturating); no Start.
//    BUSY, Done and frame_done in the same cycle: handoff as in IDLE (Start pulsed, bank swap),
//                                 stay BUSY, no overrun.
//    IDLE, Done:                  ignored.
//  - Start is registered and high for exactly one cycle per handoff. It is never high two cycles in a row.
//  - Busy = (state==BUSY); it rises in the same cycle as Start.
//  - Read path: Rd_Data <= mem[{rd_bank,Rd_Addr}] each cycle. The read bank is never the write bank.
//  - Clr_Ovr: clears Overrun and Drop_Count next cycle.
//    If Clr_Ovr and an overrun occur in the same cycle, the overrun wins: Overrun=1, Drop_Count=1.
//  - Reset mid-frame discards the partial frame. Reset while BUSY abandons the held frame.
//  - Sample_Valid gaps of any length are allowed; there is no timeout.
// STRUCTURE
//  - Shared package veritune_pkg: SAMPLE_W, FRAME_LEN, ADDR_W, FSM state localparams (IDLE, BUSY).
//  - Sub-module frame_ram: simple dual-port RAM, 2*FRAME_LEN x SAMPLE_W.
//    One write port, one registered read port, address {bank,idx}.
//  - Top level holds the write counter, bank pointers, handoff FSM and overrun logic.
// TESTING
//  1. Reset; 256 valid samples with value i; Done=0 -> Start pulses once, 1 cycle after sample 255;
//     Busy=1; Rd_Addr=5 -> Rd_Data=5 next cycle.
//  2. During frame 2 (values 256+i) pulse Done; complete frame 2 -> Start pulses again;
//     Rd_Addr=5 -> Rd_Data=261; Overrun=0.
//  3. Hold Done=0 through frames 2 and 3 -> Overrun=1, Drop_Count=2, no Start, Rd_Data still frame 1.
//     Then pulse Done and send frame 4 -> Start pulses. Clr_Ovr -> Overrun=0, Drop_Count=0.
//  4. Done and sample 255 of a frame in the same cycle while BUSY -> Start pulses,
//     Busy stays 1, Overrun stays 0.
//  5. Assert Reset after sample 100 -> all outputs reset. The next 256 samples give exactly one Start;
//     Rd_Addr=0 -> the first post-reset sample.
//  6. Sample_Valid every 3rd cycle, else as scenario 1 -> identical Start and Rd_Data results.

Source files
------------

// File: rtl/veritune_pkg.sv
`default_nettype none
// ============================================================================
//  Package   : veritune_pkg
//  Purpose   : Constants and types shared by the frame capture block
//              (sample width, frame geometry, handoff FSM states).
//  Revision  : 1.0  initial release
// ============================================================================
package veritune_pkg;

    localparam int SAMPLE_W  = 16;   // bits per audio sample
    localparam int FRAME_LEN = 256;  // samples per frame (power of two)
    localparam int ADDR_W    = 8;    // log2(FRAME_LEN)
    localparam int CNT_W     = 8;    // dropped-frame counter width

    // Handoff FSM: IDLE = no frame owned by the shifter, BUSY = shifter owns one
    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

endpackage : veritune_pkg
`default_nettype wire

// File: rtl/frame_capture_if.sv
`default_nettype none
// ============================================================================
//  Interface : frame_capture_if
//  Purpose   : Bundles the sample-input, shifter handshake and read-port
//              signals of frame_capture.
//  Signals   : Sample_In/Sample_Valid  sample stream in
//              Done                    shifter finished the held frame
//              Clr_Ovr                 clears Overrun and Drop_Count
//              Rd_Addr/Rd_Data         registered read port into held frame
//              Start/Busy              handoff pulse / shifter owns a frame
//              Overrun/Drop_Count      dropped-frame status
//  Modports  : master - upstream source and shifter side
//              slave  - frame_capture side
//  Revision  : 1.0  initial release
// ============================================================================
interface frame_capture_if;
    import veritune_pkg::*;

    logic [SAMPLE_W-1:0] Sample_In;
    logic                Sample_Valid;
    logic                Done;
    logic                Clr_Ovr;
    logic [ADDR_W-1:0]   Rd_Addr;
    logic [SAMPLE_W-1:0] Rd_Data;
    logic                Start;
    logic                Busy;
    logic                Overrun;
    logic [CNT_W-1:0]    Drop_Count;

    modport master (
        output Sample_In, Sample_Valid, Done, Clr_Ovr, Rd_Addr,
        input  Rd_Data, Start, Busy, Overrun, Drop_Count
    );

    modport slave (
        input  Sample_In, Sample_Valid, Done, Clr_Ovr, Rd_Addr,
        output Rd_Data, Start, Busy, Overrun, Drop_Count
    );

endinterface : frame_capture_if
`default_nettype wire

// File: rtl/frame_capture_ram.sv
`default_nettype none
// ============================================================================
//  Module    : frame_capture_ram (frame_ram)
//  Purpose   : Simple dual-port RAM, 2*FRAME_LEN x SAMPLE_W, holding the
//              two ping-pong frame banks. Address is {bank, idx}.
//  Ports     : clk, rst      clock, async active-high reset (read reg only)
//              i_wr_en       write strobe
//              i_wr_addr     write address {bank, idx}
//              i_wr_data     write data
//              i_rd_addr     read address {bank, idx}
//              o_rd_data     registered read data, 1-cycle latency
//  Revision  : 1.0  initial release
// ============================================================================
module frame_ram
    import veritune_pkg::*;
(
    input  wire logic                clk,
    input  wire logic                rst,
    input  wire logic                i_wr_en,
    input  wire logic [ADDR_W:0]     i_wr_addr,
    input  wire logic [SAMPLE_W-1:0] i_wr_data,
    input  wire logic [ADDR_W:0]     i_rd_addr,
    output logic      [SAMPLE_W-1:0] o_rd_data
);

    localparam int C_DEPTH = 2 * FRAME_LEN;

    logic [SAMPLE_W-1:0] mem [C_DEPTH];

    // Storage array is deliberately not reset so it maps onto block RAM.
    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            mem[i_wr_addr] <= i_wr_data;
        end
    end

    // Output register carries the reset so Rd_Data reads zero out of reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o_rd_data <= '0;
        end else begin
            o_rd_data <= mem[i_rd_addr];
        end
    end

endmodule : frame_ram
`default_nettype wire

// File: rtl/frame_capture.sv
`default_nettype none
// ============================================================================
//  Module    : frame_capture
//  Purpose   : Ping-pong sample buffer upstream of the pitch shifter.
//              Collects samples into FRAME_LEN frames, hands each completed
//              frame over with a one-cycle Start pulse, serves the held frame
//              through a registered read port, and counts dropped frames.
//  Ports     : Clk    system clock, rising edge
//              Reset  asynchronous active-high reset
//              bus    frame_capture_if.slave (see interface for signals)
//  Revision  : 1.0  initial release
// ============================================================================
module frame_capture
    import veritune_pkg::*;
(
    input  wire logic      Clk,
    input  wire logic      Reset,
    frame_capture_if.slave bus
);

    localparam logic [ADDR_W-1:0] C_LAST_IDX = ADDR_W'(FRAME_LEN - 1);
    localparam logic [CNT_W-1:0]  C_CNT_MAX  = '1;

    state_t           state_q, state_d;
    logic [ADDR_W-1:0] wr_idx_q, wr_idx_d;
    logic             wr_bank_q, wr_bank_d;
    logic             rd_bank_q, rd_bank_d;
    logic             start_q, start_d;
    logic             overrun_q, overrun_d;
    logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;

    logic w_frame_done;
    logic w_handoff;
    logic w_overrun;

    // ------------------------------------------------------------------
    // Next-state logic: write counter, handoff FSM, overrun bookkeeping
    // ------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        wr_idx_d   = wr_idx_q;
        wr_bank_d  = wr_bank_q;
        rd_bank_d  = rd_bank_q;
        start_d    = 1'b0;
        overrun_d  = overrun_q;
        drop_cnt_d = drop_cnt_q;
        w_handoff  = 1'b0;
        w_overrun  = 1'b0;

        w_frame_done = bus.Sample_Valid && (wr_idx_q == C_LAST_IDX);

        // Index wraps naturally at FRAME_LEN (power of two).
        if (bus.Sample_Valid) begin
            wr_idx_d = wr_idx_q + 1'b1;
        end

        case (state_q)
            IDLE: begin
                // A stray Done while idle is ignored.
                if (w_frame_done) begin
                    w_handoff = 1'b1;
                    state_d   = BUSY;
                end
            end
            BUSY: begin
                if (w_frame_done && bus.Done) begin
                    // Shifter frees the old frame as the new one completes:
                    // hand over immediately and remain busy.
                    w_handoff = 1'b1;
                end else if (w_frame_done) begin
                    w_overrun = 1'b1;
                end else if (bus.Done) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (w_handoff) begin
            rd_bank_d = wr_bank_q;
            wr_bank_d = ~wr_bank_q;
            start_d   = 1'b1;
        end

        // On overrun the write bank stays put, so the next frame simply
        // overwrites the dropped one. An overrun beats a same-cycle clear.
        if (w_overrun) begin
            overrun_d = 1'b1;
            if (bus.Clr_Ovr) begin
                drop_cnt_d = CNT_W'(1);
            end else if (drop_cnt_q != C_CNT_MAX) begin
                drop_cnt_d = drop_cnt_q + 1'b1;
            end
        end else if (bus.Clr_Ovr) begin
            overrun_d  = 1'b0;
            drop_cnt_d = '0;
        end
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q    <= IDLE;
            wr_idx_q   <= '0;
            wr_bank_q  <= 1'b0;
            rd_bank_q  <= 1'b1;
            start_q    <= 1'b0;
            overrun_q  <= 1'b0;
            drop_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            wr_idx_q   <= wr_idx_d;
            wr_bank_q  <= wr_bank_d;
            rd_bank_q  <= rd_bank_d;
            start_q    <= start_d;
            overrun_q  <= overrun_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    // ------------------------------------------------------------------
    // Frame storage
    // ------------------------------------------------------------------
    frame_ram u_frame_ram (
        .clk       (Clk),
        .rst       (Reset),
        .i_wr_en   (bus.Sample_Valid),
        .i_wr_addr ({wr_bank_q, wr_idx_q}),
        .i_wr_data (bus.Sample_In),
        .i_rd_addr ({rd_bank_q, bus.Rd_Addr}),
        .o_rd_data (bus.Rd_Data)
    );

    assign bus.Start      = start_q;
    assign bus.Busy       = (state_q == BUSY);
    assign bus.Overrun    = overrun_q;
    assign bus.Drop_Count = drop_cnt_q;

endmodule : frame_capture
`default_nettype wire

// File: tb/tb_frame_capture.sv
`default_nettype none
// ============================================================================
//  Module    : tb_frame_capture
//  Purpose   : Self-checking bench for frame_capture: frame handoff, read
//              port contents, overrun/drop counting, clear priority,
//              simultaneous Done/frame completion, async reset, gapped input.
//  Revision  : 1.0  initial release
// ============================================================================
module tb_frame_capture;
    import veritune_pkg::*;

    logic Clk;
    logic Reset;

    frame_capture_if bus ();

    frame_capture dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus.slave)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    int checks;
    int errors;
    int start_cnt;
    int twice_cnt;
    logic prev_start;

    // Start pulse monitor, sampled mid-cycle.
    initial begin
        start_cnt  = 0;
        twice_cnt  = 0;
        prev_start = 1'b0;
        forever begin
            @(negedge Clk);
            if (bus.Start === 1'b1) begin
                start_cnt++;
                if (prev_start === 1'b1) twice_cnt++;
            end
            prev_start = bus.Start;
        end
    end

    typedef struct {
        logic [ADDR_W-1:0] addr;
        int                exp_rel;  // expected sample minus frame base
    } rd_vec_t;

    rd_vec_t vec [5];

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    // Send n samples base+i; gap idle cycles precede each sample.
    task automatic send_frame(input int base, input int n, input int gap,
                              input int done_idx, input int clr_idx);
        for (int i = 0; i < n; i++) begin
            repeat (gap) tick();
            bus.Sample_Valid = 1'b1;
            bus.Sample_In    = SAMPLE_W'(base + i);
            bus.Done         = (i == done_idx);
            bus.Clr_Ovr      = (i == clr_idx);
            tick();
            bus.Sample_Valid = 1'b0;
            bus.Done         = 1'b0;
            bus.Clr_Ovr      = 1'b0;
        end
    endtask

    task automatic read_table(input string name, input int base);
        for (int k = 0; k < 5; k++) begin
            bus.Rd_Addr = vec[k].addr;
            tick();
            chk($sformatf("%s_rd[%0d]", name, vec[k].addr), bus.Rd_Data,
                longint'(base + vec[k].exp_rel) & 64'hFFFF);
        end
    endtask

    task automatic read_one(input string name, input int addr, input int exp);
        bus.Rd_Addr = ADDR_W'(addr);
        tick();
        chk(name, bus.Rd_Data, exp);
    endtask

    task automatic pulse_clr();
        bus.Clr_Ovr = 1'b1;
        tick();
        bus.Clr_Ovr = 1'b0;
    endtask

    int s0;

    initial begin
        checks = 0;
        errors = 0;
        vec[0] = '{addr: 8'd0,   exp_rel: 0};
        vec[1] = '{addr: 8'd5,   exp_rel: 5};
        vec[2] = '{addr: 8'd128, exp_rel: 128};
        vec[3] = '{addr: 8'd254, exp_rel: 254};
        vec[4] = '{addr: 8'd255, exp_rel: 255};

        Reset            = 1'b1;
        bus.Sample_In    = '0;
        bus.Sample_Valid = 1'b0;
        bus.Done         = 1'b0;
        bus.Clr_Ovr      = 1'b0;
        bus.Rd_Addr      = '0;
        repeat (3) tick();

        // Reset values
        chk("rst_start",   bus.Start,      0);
        chk("rst_busy",    bus.Busy,       0);
        chk("rst_overrun", bus.Overrun,    0);
        chk("rst_drop",    bus.Drop_Count, 0);
        chk("rst_rddata",  bus.Rd_Data,    0);
        Reset = 1'b0;
        tick();

        // 1: first frame, Start one cycle after sample 255
        s0 = start_cnt;
        send_frame(0, 256, 0, -1, -1);
        chk("s1_start", bus.Start, 1);
        chk("s1_busy",  bus.Busy,  1);
        tick();
        chk("s1_start_low", bus.Start, 0);
        read_table("s1", 0);
        chk("s1_start_cnt", start_cnt - s0, 1);

        // 2: Done mid-frame, frame 2 handed off
        s0 = start_cnt;
        send_frame(256, 256, 0, 10, -1);
        chk("s2_start", bus.Start, 1);
        read_table("s2", 256);
        chk("s2_overrun", bus.Overrun, 0);
        chk("s2_start_cnt", start_cnt - s0, 1);

        // 3: two frames dropped while the shifter holds frame 2
        s0 = start_cnt;
        send_frame(512, 256, 0, -1, -1);
        send_frame(768, 256, 0, -1, -1);
        chk("s3_overrun",   bus.Overrun,    1);
        chk("s3_drop",      bus.Drop_Count, 2);
        chk("s3_start_cnt", start_cnt - s0, 0);
        chk("s3_busy",      bus.Busy,       1);
        read_one("s3_held_rd5", 5, 261);
        bus.Done = 1'b1;
        tick();
        bus.Done = 1'b0;
        chk("s3_idle", bus.Busy, 0);
        send_frame(1024, 256, 0, -1, -1);
        chk("s3_start", bus.Start, 1);
        read_one("s3_new_rd5", 5, 1029);
        chk("s3_ovr_sticky", bus.Overrun, 1);
        pulse_clr();
        chk("s3_clr_ovr",  bus.Overrun,    0);
        chk("s3_clr_drop", bus.Drop_Count, 0);

        // Overrun and clear in the same cycle: overrun wins
        send_frame(1280, 256, 0, -1, 255);
        chk("clr_race_ovr",  bus.Overrun,    1);
        chk("clr_race_drop", bus.Drop_Count, 1);
        pulse_clr();
        chk("clr_race_cleared", bus.Drop_Count, 0);

        // 4: Done together with sample 255 while busy
        s0 = start_cnt;
        send_frame(1536, 256, 0, 255, -1);
        chk("s4_start",   bus.Start,   1);
        chk("s4_busy",    bus.Busy,    1);
        chk("s4_overrun", bus.Overrun, 0);
        tick();
        chk("s4_busy_hold", bus.Busy, 1);
        read_one("s4_rd5", 5, 1541);
        chk("s4_start_cnt", start_cnt - s0, 1);

        // 5: asynchronous reset mid-frame
        send_frame(4000, 101, 0, -1, -1);
        Reset = 1'b1;
        #1;
        chk("s5_busy",   bus.Busy,    0);
        chk("s5_start",  bus.Start,   0);
        chk("s5_rddata", bus.Rd_Data, 0);
        chk("s5_ovr",    bus.Overrun, 0);
        tick();
        Reset = 1'b0;
        tick();
        s0 = start_cnt;
        send_frame(2000, 256, 0, -1, -1);
        chk("s5_start_after", bus.Start, 1);
        read_one("s5_rd0", 0, 2000);
        chk("s5_start_cnt", start_cnt - s0, 1);

        // 6: Sample_Valid every third cycle
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        tick();
        s0 = start_cnt;
        send_frame(0, 256, 2, -1, -1);
        chk("s6_start", bus.Start, 1);
        chk("s6_busy",  bus.Busy,  1);
        read_table("s6", 0);
        chk("s6_start_cnt", start_cnt - s0, 1);

        tick();
        chk("start_never_twice", twice_cnt, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_frame_capture
`default_nettype wire
